hazard_pipe_ctrl: RTL and testbench

HAZARD_PIPE_CTRL -- requirements
Module: hazard_pipe_ctrl

---
 rtl/hazard_pipe_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_pipe_ctrl
//
// Purpose:
//   Tracks the destination-register specifiers in the EX, MEM and WB stages of
//   a simple in-order pipeline. Inserts bubbles into EX on data-hazard stalls,
//   fetch redirects and invalid ID slots. Arbitrates the register-file write
//   port between the pipeline and an external network agent.
//
//   To arbitrate the write port, a small FSM (IDLE -> DRAIN -> WRITE) first
//   holds IF/ID. It then waits until EX, MEM and WB carry no pending
//   destination. It then grants the write port to the network for exactly one
//   cycle.
//
// Ports:
//   clk                  pipeline clock, all state on rising edge
//   reset                synchronous active-high reset
//   dec_valid_i          ID stage holds a valid instruction
//   dec_op_dest_i        destination specifier of the ID instruction (0 = none)
//   stall_i              data-hazard stall request for the ID instruction
//   flush_i              fetch redirect, kills the ID instruction this cycle
//   net_reg_write_cmd_i  network register-file write request (level)
//   ex_op_dest_o         destination specifier in EX
//   m_op_dest_o          destination specifier in MEM
//   wb_op_dest_o         destination specifier in WB
//   pipeline_stall_o     overall stall indication
//   IF_stall_o           hold fetch stage
//   ID_stall_o           hold decode stage
//   net_write_en_o       one-cycle register-file write grant to the network
//   bubble_count_o       saturating count of stall bubbles inserted
// -----------------------------------------------------------------------------
module hazard_pipe_ctrl #(
    parameter int unsigned reg_width = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_valid_i,
    input  logic [reg_width-1:0] dec_op_dest_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 net_reg_write_cmd_i,
    output logic [reg_width-1:0] ex_op_dest_o,
    output logic [reg_width-1:0] m_op_dest_o,
    output logic [reg_width-1:0] wb_op_dest_o,
    output logic                 pipeline_stall_o,
    output logic                 IF_stall_o,
    output logic                 ID_stall_o,
    output logic                 net_write_en_o,
    output logic [15:0]          bubble_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [reg_width-1:0] ex_dest_q, ex_dest_d;
    logic [reg_width-1:0] m_dest_q, m_dest_d;
    logic [reg_width-1:0] wb_dest_q, wb_dest_d;
    logic [15:0]          bubble_count_q, bubble_count_d;
    logic                 net_write_en_q, net_write_en_d;

    logic                 fsm_busy_s;
    logic                 pipe_empty_s;
    logic                 issue_s;
    logic                 stall_bubble_s;

    // Decode of current state and pipeline occupancy.
    always_comb begin
        fsm_busy_s     = (state_q != ST_IDLE);
        pipe_empty_s   = (ex_dest_q == '0) && (m_dest_q == '0) && (wb_dest_q == '0);
        // The ID instruction moves into EX only when nothing holds it back.
        issue_s        = dec_valid_i && !stall_i && !flush_i && !fsm_busy_s;
        // Only valid, non-flushed instructions that are held count as bubbles.
        stall_bubble_s = dec_valid_i && !flush_i && (stall_i || fsm_busy_s);
    end

    // Network write FSM next-state logic; flush has no influence here.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (net_reg_write_cmd_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pipeline shift, bubble counter and registered write-grant next values.
    always_comb begin
        // EX never freezes: it takes the ID instruction or a bubble.
        if (issue_s) begin
            ex_dest_d = dec_op_dest_i;
        end else begin
            ex_dest_d = '0;
        end
        m_dest_d  = ex_dest_q;
        wb_dest_d = m_dest_q;

        if (stall_bubble_s && (bubble_count_q != 16'hFFFF)) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end else begin
            bubble_count_d = bubble_count_q;
        end

        // The grant flop mirrors the WRITE state, so the output has no input path.
        net_write_en_d = (state_d == ST_WRITE);
    end

    // State registers with synchronous reset overriding every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ex_dest_q      <= '0;
            m_dest_q       <= '0;
            wb_dest_q      <= '0;
            bubble_count_q <= 16'd0;
            net_write_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ex_dest_q      <= ex_dest_d;
            m_dest_q       <= m_dest_d;
            wb_dest_q      <= wb_dest_d;
            bubble_count_q <= bubble_count_d;
            net_write_en_q <= net_write_en_d;
        end
    end

    // Stall outputs: flush always lets the redirect load into IF/ID.
    always_comb begin
        pipeline_stall_o = stall_i || fsm_busy_s;
        IF_stall_o       = pipeline_stall_o && !flush_i;
        ID_stall_o       = pipeline_stall_o && !flush_i;
    end

    assign ex_op_dest_o   = ex_dest_q;
    assign m_op_dest_o    = m_dest_q;
    assign wb_op_dest_o   = wb_dest_q;
    assign net_write_en_o = net_write_en_q;
    assign bubble_count_o = bubble_count_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_pipe_ctrl
//
// Directed testbench for hazard_pipe_ctrl. A single linear stimulus sequence
// is checked against hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_hazard_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        dec_valid_i;
    logic [5:0]  dec_op_dest_i;
    logic        stall_i;
    logic        flush_i;
    logic        net_reg_write_cmd_i;
    logic [5:0]  ex_op_dest_o;
    logic [5:0]  m_op_dest_o;
    logic [5:0]  wb_op_dest_o;
    logic        pipeline_stall_o;
    logic        IF_stall_o;
    logic        ID_stall_o;
    logic        net_write_en_o;
    logic [15:0] bubble_count_o;

    int vec_cnt  = 0;
    int fail_cnt = 0;

    hazard_pipe_ctrl #(.reg_width(6)) dut (
        .clk                 (clk),
        .reset               (reset),
        .dec_valid_i         (dec_valid_i),
        .dec_op_dest_i       (dec_op_dest_i),
        .stall_i             (stall_i),
        .flush_i             (flush_i),
        .net_reg_write_cmd_i (net_reg_write_cmd_i),
        .ex_op_dest_o        (ex_op_dest_o),
        .m_op_dest_o         (m_op_dest_o),
        .wb_op_dest_o        (wb_op_dest_o),
        .pipeline_stall_o    (pipeline_stall_o),
        .IF_stall_o          (IF_stall_o),
        .ID_stall_o          (ID_stall_o),
        .net_write_en_o      (net_write_en_o),
        .bubble_count_o      (bubble_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then read 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt = vec_cnt + 1;
        assert (obs === exp) else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pipe(input string tag, input logic [5:0] ex, input logic [5:0] m, input logic [5:0] wb);
        chk({tag, ".ex"}, {10'd0, ex_op_dest_o}, {10'd0, ex});
        chk({tag, ".m"},  {10'd0, m_op_dest_o},  {10'd0, m});
        chk({tag, ".wb"}, {10'd0, wb_op_dest_o}, {10'd0, wb});
    endtask

    task automatic chk_stall(input string tag, input logic ps, input logic ifs, input logic ids);
        chk({tag, ".pstall"},  {15'd0, pipeline_stall_o}, {15'd0, ps});
        chk({tag, ".ifstall"}, {15'd0, IF_stall_o},       {15'd0, ifs});
        chk({tag, ".idstall"}, {15'd0, ID_stall_o},       {15'd0, ids});
    endtask

    initial begin
        reset               = 1'b1;
        dec_valid_i         = 1'b0;
        dec_op_dest_i       = 6'd0;
        stall_i             = 1'b0;
        flush_i             = 1'b0;
        net_reg_write_cmd_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        chk_pipe("rst", 6'd0, 6'd0, 6'd0);
        chk("rst.we",     {15'd0, net_write_en_o}, 16'd0);
        chk("rst.bubble", bubble_count_o, 16'd0);
        chk_stall("rst", 1'b0, 1'b0, 1'b0);

        // Issue 5,6,7 back to back; WB shows them 3,4,5 cycles later.
        dec_valid_i = 1'b1; dec_op_dest_i = 6'd5; tick();
        chk_pipe("iss1", 6'd5, 6'd0, 6'd0);
        dec_op_dest_i = 6'd6; tick();
        chk_pipe("iss2", 6'd6, 6'd5, 6'd0);
        dec_op_dest_i = 6'd7; tick();
        chk_pipe("iss3", 6'd7, 6'd6, 6'd5);
        dec_valid_i = 1'b0; tick();
        chk_pipe("iss4", 6'd0, 6'd7, 6'd6);
        tick();
        chk_pipe("iss5", 6'd0, 6'd0, 6'd7);
        tick();
        chk_pipe("iss6", 6'd0, 6'd0, 6'd0);
        chk("iss.bubble", bubble_count_o, 16'd0);

        // Stall of dest 9 for two cycles, then it issues.
        dec_valid_i = 1'b1; dec_op_dest_i = 6'd9; stall_i = 1'b1; #1;
        chk_stall("st1", 1'b1, 1'b1, 1'b1);
        tick();
        chk("st1.ex", {10'd0, ex_op_dest_o}, 16'd0);
        chk("st1.bubble", bubble_count_o, 16'd1);
        chk_stall("st2", 1'b1, 1'b1, 1'b1);
        tick();
        chk("st2.ex", {10'd0, ex_op_dest_o}, 16'd0);
        chk("st2.bubble", bubble_count_o, 16'd2);
        stall_i = 1'b0; #1;
        chk_stall("st3", 1'b0, 1'b0, 1'b0);
        tick();
        chk("st3.ex", {10'd0, ex_op_dest_o}, 16'd9);
        chk("st3.bubble", bubble_count_o, 16'd2);

        // Invalid ID slot with stall must not count.
        dec_valid_i = 1'b0; stall_i = 1'b1; tick();
        chk("inv.bubble", bubble_count_o, 16'd2);
        stall_i = 1'b0;

        // Fill pipe with 3,4,5 then drain for a network write.
        dec_valid_i = 1'b1; dec_op_dest_i = 6'd3; tick();
        dec_op_dest_i = 6'd4; tick();
        dec_op_dest_i = 6'd5; tick();
        chk_pipe("fill", 6'd5, 6'd4, 6'd3);
        dec_valid_i = 1'b0; net_reg_write_cmd_i = 1'b1; #1;
        chk_stall("dr0", 1'b0, 1'b0, 1'b0);
        tick();
        net_reg_write_cmd_i = 1'b0; #1;
        chk_pipe("dr1", 6'd0, 6'd5, 6'd4);
        chk("dr1.we", {15'd0, net_write_en_o}, 16'd0);
        chk_stall("dr1", 1'b1, 1'b1, 1'b1);
        tick();
        chk("dr2.we", {15'd0, net_write_en_o}, 16'd0);
        chk_stall("dr2", 1'b1, 1'b1, 1'b1);
        tick();
        chk_pipe("dr3", 6'd0, 6'd0, 6'd0);
        chk("dr3.we", {15'd0, net_write_en_o}, 16'd0);
        chk_stall("dr3", 1'b1, 1'b1, 1'b1);
        tick();
        chk("wr.we", {15'd0, net_write_en_o}, 16'd1);
        chk_stall("wr", 1'b1, 1'b1, 1'b1);
        tick();
        chk("idle.we", {15'd0, net_write_en_o}, 16'd0);
        chk_stall("idle", 1'b0, 1'b0, 1'b0);
        chk("dr.bubble", bubble_count_o, 16'd2);

        // Flush together with stall: bubble, stall outputs masked, no count.
        dec_valid_i = 1'b1; dec_op_dest_i = 6'd8; stall_i = 1'b1; flush_i = 1'b1; #1;
        chk_stall("fl", 1'b1, 1'b0, 1'b0);
        tick();
        chk("fl.ex", {10'd0, ex_op_dest_o}, 16'd0);
        chk("fl.bubble", bubble_count_o, 16'd2);
        stall_i = 1'b0; flush_i = 1'b0;

        // Reset in the second DRAIN cycle aborts the write.
        dec_op_dest_i = 6'd1; tick();
        dec_op_dest_i = 6'd2; tick();
        dec_valid_i = 1'b0; net_reg_write_cmd_i = 1'b1; tick();
        chk_pipe("ra1", 6'd0, 6'd2, 6'd1);
        tick();
        chk_pipe("ra2", 6'd0, 6'd0, 6'd2);
        chk_stall("ra2", 1'b1, 1'b1, 1'b1);
        reset = 1'b1; dec_valid_i = 1'b1; dec_op_dest_i = 6'd11; flush_i = 1'b1; tick();
        reset = 1'b0; dec_valid_i = 1'b0; flush_i = 1'b0; #1;
        chk_pipe("ra3", 6'd0, 6'd0, 6'd0);
        chk("ra3.we", {15'd0, net_write_en_o}, 16'd0);
        chk("ra3.bubble", bubble_count_o, 16'd0);
        chk_stall("ra3", 1'b0, 1'b0, 1'b0);
        tick();
        chk("ra4.we", {15'd0, net_write_en_o}, 16'd0);
        chk_stall("ra4", 1'b1, 1'b1, 1'b1);
        tick();
        chk("ra5.we", {15'd0, net_write_en_o}, 16'd1);
        // Command still high: back to IDLE, then re-enter DRAIN.
        tick();
        chk("ra6.we", {15'd0, net_write_en_o}, 16'd0);
        chk_stall("ra6", 1'b0, 1'b0, 1'b0);
        tick();
        net_reg_write_cmd_i = 1'b0; #1;
        chk_stall("ra7", 1'b1, 1'b1, 1'b1);
        chk("ra7.we", {15'd0, net_write_en_o}, 16'd0);
        tick();
        chk("ra8.we", {15'd0, net_write_en_o}, 16'd1);
        tick();
        chk("ra9.we", {15'd0, net_write_en_o}, 16'd0);
        chk_stall("ra9", 1'b0, 1'b0, 1'b0);

        // Saturation of the bubble counter.
        dec_valid_i = 1'b1; dec_op_dest_i = 6'd4; stall_i = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        chk("sat.fffe", bubble_count_o, 16'hFFFE);
        tick();
        chk("sat.1", bubble_count_o, 16'hFFFF);
        tick();
        chk("sat.2", bubble_count_o, 16'hFFFF);
        tick();
        chk("sat.3", bubble_count_o, 16'hFFFF);
        dec_valid_i = 1'b0; stall_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
